// File: rtl/int_ctrl_prio.sv
`default_nettype none
// ============================================================================
// int_ctrl_prio : two-level (low/high) nesting interrupt controller for 8051.
// Optional: INTC_RETI_HOLDOFF_EN forces one instruction after RETI.
// Revision 1.0
// ============================================================================
module int_ctrl_prio #(
    parameter int               NUM_SRC    = 5,
    parameter int               VEC_W      = 16,
    parameter logic [VEC_W-1:0] VEC_BASE   = 16'h0003,
    parameter int               VEC_STRIDE = 8,
    localparam int              ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ea,
    input  logic [NUM_SRC-1:0] ie_en,
    input  logic [NUM_SRC-1:0] ip_hi,
    input  logic [NUM_SRC-1:0] src_flag,
    input  logic [NUM_SRC-1:0] src_auto_clr,
    input  logic               cpu_int_ok,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [VEC_W-1:0]   int_vec,
    output logic [NUM_SRC-1:0] flag_clr,
    output logic               in_svc_lo,
    output logic               in_svc_hi
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] elig, elig_hi, elig_lo, id_hit, flag_clr_nxt;
    logic               cand_vld, cand_lvl, grant_ok, still_pend;
    logic [ID_W-1:0]    cand_id, id_nxt;
    logic [VEC_W-1:0]   vec_nxt;
    logic               lvl, lvl_nxt, svc_lo_nxt, svc_hi_nxt;

    // A source may only interrupt a strictly lower active level.
    assign elig    = {NUM_SRC{ea}} & ie_en & src_flag;
    assign elig_hi = in_svc_hi ? '0 : (elig & ip_hi);
    assign elig_lo = (in_svc_hi | in_svc_lo) ? '0 : (elig & ~ip_hi);

    always_comb begin : arb
        cand_vld = 1'b0;
        cand_lvl = 1'b0;
        cand_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig_lo[i]) begin
                cand_vld = 1'b1;
                cand_lvl = 1'b0;
                cand_id  = ID_W'(i);
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig_hi[i]) begin
                cand_vld = 1'b1;
                cand_lvl = 1'b1;
                cand_id  = ID_W'(i);
            end
        end
    end

    always_comb begin : sel
        for (int i = 0; i < NUM_SRC; i++) begin
            id_hit[i] = (int_id == ID_W'(i));
        end
    end

    assign still_pend = ea & (|(id_hit & ie_en & src_flag));

`ifdef INTC_RETI_HOLDOFF_EN
    logic holdoff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            holdoff <= 1'b0;
        end else if (reti) begin
            holdoff <= 1'b1;
        end else if (cpu_int_ok) begin
            holdoff <= 1'b0;
        end
    end

    assign grant_ok = cpu_int_ok & ~holdoff;
`else
    assign grant_ok = cpu_int_ok;
`endif

    always_comb begin : fsm_comb
        state_nxt    = state;
        id_nxt       = int_id;
        vec_nxt      = int_vec;
        lvl_nxt      = lvl;
        flag_clr_nxt = '0;
        svc_lo_nxt   = in_svc_lo;
        svc_hi_nxt   = in_svc_hi;
        // RETI retires the innermost level before any same-cycle ack sets one.
        if (reti) begin
            if (in_svc_hi) begin
                svc_hi_nxt = 1'b0;
            end else begin
                svc_lo_nxt = 1'b0;
            end
        end
        case (state)
            IDLE: begin
                if (cand_vld && grant_ok) begin
                    state_nxt = REQ;
                    id_nxt    = cand_id;
                    vec_nxt   = VEC_BASE + VEC_W'(cand_id) * VEC_W'(VEC_STRIDE);
                    lvl_nxt   = cand_lvl;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nxt    = IDLE;
                    flag_clr_nxt = id_hit & src_auto_clr;
                    if (lvl) begin
                        svc_hi_nxt = 1'b1;
                    end else begin
                        svc_lo_nxt = 1'b1;
                    end
                end else if (!still_pend) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            int_id    <= '0;
            int_vec   <= VEC_BASE;
            lvl       <= 1'b0;
            flag_clr  <= '0;
            in_svc_lo <= 1'b0;
            in_svc_hi <= 1'b0;
        end else begin
            state     <= state_nxt;
            int_id    <= id_nxt;
            int_vec   <= vec_nxt;
            lvl       <= lvl_nxt;
            flag_clr  <= flag_clr_nxt;
            in_svc_lo <= svc_lo_nxt;
            in_svc_hi <= svc_hi_nxt;
        end
    end

    assign int_req = (state == REQ);

endmodule
`default_nettype wire
